fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the control unit. It holds the program counter and presents the 9-bit instruction to the decoder. It consumes the decoder's `branch`, `jmp_ctrl` and `done_ctrl` flags together with the ALU compare result to select the next PC. It also sequences the run/halt lifecycle of the processor and counts executed cycles.

## Interface
- `PC_WIDTH`, default 8: program counter width; instruction ROM depth is 2^PC_WIDTH.
- `CNT_WIDTH`, default 16: cycle counter width.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins execution.
- `start_addr`  in  PC_WIDTH  PC loaded on an accepted `start`.
- `instr_rdata`  in  9  external ROM data; combinational read of `pc`.
- `branch`  in  1  control unit: the current instruction is beq/blt.
- `branch_taken`  in  1  ALU: the compare condition holds.
- `jmp_ctrl`  in  1  control unit: the current instruction is a jump.
- `jump_target`  in  PC_WIDTH  absolute jump address from the register file.
- `done_ctrl`  in  1  control unit: the current instruction is halt.
- `pc`  out  PC_WIDTH  ROM address.
- `instruction`  out  9  to the control unit; equals `instr_rdata`.
- `instr_valid`  out  1  high only in RUN; downstream gates reg/mem writes with it.
- `done`  out  1  high in HALTED.
- `cycle_count`  out  CNT_WIDTH  RUN cycles executed.

## Operation
- State machine: IDLE, RUN, HALTED.
  - IDLE: `start` → RUN, `pc` ← `start_addr`, `cycle_count` ← 0.
  - RUN: `done_ctrl` → HALTED, `pc` holds. Otherwise `pc` ← next PC.
  - HALTED: `start` → RUN, with `pc` ← `start_addr` and `cycle_count` ← 0. Otherwise hold.
- `start` is ignored in RUN.
- `branch`, `jmp_ctrl`, `branch_taken` and `done_ctrl` are ignored outside RUN.
- Next PC in RUN, highest priority first:
  1. `done_ctrl`: hold.
  2. `jmp_ctrl`: `jump_target`.
  3. `branch && branch_taken`: `pc` + sign-extended `instruction[4:0]`. Offset range is −16..+15, relative to the branch's own PC.
  4. Otherwise: `pc` + 1.
- All PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent in both directions.
- `cycle_count` increments on every RUN cycle, including the cycle that presents halt. It saturates at all-ones and holds in IDLE and HALTED.
- `instruction` is always driven from `instr_rdata`. Validity is signalled only by `instr_valid`.

## Timing
- Reset values: state IDLE, `pc` 0, `instr_valid` 0, `done` 0, `cycle_count` 0.
- Asserting `reset` at any point, including mid-RUN, takes effect immediately without waiting for a clock edge.
- Single-cycle datapath: `pc` → ROM → decoder → next-PC select is combinational. `pc` updates on the following rising edge, so there is one instruction per cycle and no branch penalty.
- `start` sampled in IDLE gives `instr_valid` = 1 on the next cycle, with the instruction at `start_addr` presented.
- A halt presented in cycle N gives `done` = 1 and `instr_valid` = 0 from cycle N+1.
- `pc` stays at the halt instruction's address while HALTED.
- `done`, `instr_valid` and `cycle_count` are registered or decoded from registered state only; there is no combinational path from any input to them.

## Structure
- Shared package contents:
  - state enum `fetch_state_t` {IDLE, RUN, HALTED};
  - `PC_WIDTH` default;
  - opcode constants `spec_op` = 4'b0111 and `hlt_op` = 3'b010, shared with the control unit and used by the bench;
  - `BR_OFF_WIDTH` = 5.
- One sub-module, `next_pc_sel`: purely combinational priority mux plus offset adder. It is kept separate so it can be unit-tested with exhaustive offsets.
- The FSM, PC register and counter live in `fetch_unit`.

## Test plan
- Sequential run: reset, `start` with `start_addr` = 8'h10, ROM of three add instructions then halt (9'b0111_00_010). Expected: `pc` sequence 10, 11, 12, 13, then `done` = 1, `pc` holds at 13, `cycle_count` = 4.
- Branches:
  - Taken branch at PC 8'h20, `instruction[4:0]` = 5'b11100, `branch_taken` = 1 → next `pc` = 8'h1C.
  - Same branch with `branch_taken` = 0 → next `pc` = 8'h21.
- Wrap-around:
  - Fall-through at PC 8'hFF → next `pc` = 8'h00.
  - Branch offset +15 at PC 8'hF5 → next `pc` = 8'h04.
- Priority: `jmp_ctrl` = 1 and `done_ctrl` = 1 in the same cycle → HALTED, `pc` unchanged.
  - `jmp_ctrl` = 1 with `jump_target` = 8'h40 → next `pc` = 8'h40.
- Restart and ignores: `start` asserted during RUN → no effect. Later, `start` in HALTED with `start_addr` = 8'h05 → `pc` = 8'h05, `cycle_count` cleared, `done` = 0.
- Reset mid-RUN: assert `reset` between clock edges at PC 8'h33 → `pc` = 0 and `instr_valid` = 0 before the next edge. After release, the block stays in IDLE until `start`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its neighbours (control unit, bench).
package fetch_unit_pkg;

    // Processor lifecycle as seen by the fetch stage.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Default program counter width; ROM depth is 2**PC_WIDTH.
    localparam int unsigned DEFAULT_PC_WIDTH = 8;

    // Opcode fields shared with the control unit: halt is {spec_op, xx, hlt_op}.
    localparam logic [3:0] spec_op = 4'b0111;
    localparam logic [2:0] hlt_op  = 3'b010;

    // Branch offset lives in instruction[4:0], two's complement.
    localparam int unsigned BR_OFF_WIDTH = 5;

    // True when the instruction word encodes halt.
    function automatic logic is_halt(input logic [8:0] instr);
        return (instr[8:5] == spec_op) && (instr[2:0] == hlt_op);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: hold > jump > taken branch > fall-through.
// All arithmetic wraps modulo 2**PC_WIDTH. Requires PC_WIDTH >= BR_OFF_WIDTH.
module next_pc_sel
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH = DEFAULT_PC_WIDTH
) (
    input  logic [PC_WIDTH-1:0]     pc_i,
    input  logic [BR_OFF_WIDTH-1:0] br_off_i,
    input  logic                    hold_i,
    input  logic                    jmp_i,
    input  logic [PC_WIDTH-1:0]     jump_target_i,
    input  logic                    branch_i,
    input  logic                    branch_taken_i,
    output logic [PC_WIDTH-1:0]     next_pc_o
);

    logic [PC_WIDTH-1:0] off_ext;
    logic [PC_WIDTH-1:0] br_pc;
    logic [PC_WIDTH-1:0] seq_pc;

    // Sign-extend the offset; adding it modulo 2**PC_WIDTH gives a wrapping signed add.
    assign off_ext = {{(PC_WIDTH - BR_OFF_WIDTH){br_off_i[BR_OFF_WIDTH-1]}}, br_off_i};
    assign br_pc   = pc_i + off_ext;
    assign seq_pc  = pc_i + {{(PC_WIDTH - 1){1'b0}}, 1'b1};

    // Priority mux: the branch target is relative to the branch's own PC.
    always_comb begin
        next_pc_o = seq_pc;
        if (hold_i) begin
            next_pc_o = pc_i;
        end else if (jmp_i) begin
            next_pc_o = jump_target_i;
        end else if (branch_i && branch_taken_i) begin
            next_pc_o = br_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, run/halt lifecycle FSM and cycle counter.
// Single-cycle datapath: pc -> ROM -> decoder -> next_pc_sel is combinational.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = DEFAULT_PC_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PC_WIDTH-1:0]  start_addr,
    input  logic [8:0]           instr_rdata,
    input  logic                 branch,
    input  logic                 branch_taken,
    input  logic                 jmp_ctrl,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 done_ctrl,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [8:0]           instruction,
    output logic                 instr_valid,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    fetch_state_t         state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [PC_WIDTH-1:0]  next_pc;

    next_pc_sel #(
        .PC_WIDTH (PC_WIDTH)
    ) u_next_pc_sel (
        .pc_i           (pc_q),
        .br_off_i       (instr_rdata[BR_OFF_WIDTH-1:0]),
        .hold_i         (done_ctrl),
        .jmp_i          (jmp_ctrl),
        .jump_target_i  (jump_target),
        .branch_i       (branch),
        .branch_taken_i (branch_taken),
        .next_pc_o      (next_pc)
    );

    // Next state, PC and counter; control inputs only matter in RUN, start only outside it.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = start_addr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // The halt cycle itself still counts as executed.
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // next_pc already holds when done_ctrl is set.
                pc_d = next_pc;
                if (done_ctrl) begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and counter registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        pc          = pc_q;
        instruction = instr_rdata;
        instr_valid = (state_q == RUN);
        done        = (state_q == HALTED);
        cycle_count = cnt_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver updates a behavioural model and queues
// expected post-edge outputs; a monitor pops and compares after each rising edge.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int PW      = 8;
    localparam int CW      = 5;  // small counter so saturation is reachable
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clock;
    logic          reset;
    logic          start;
    logic [PW-1:0] start_addr;
    logic [8:0]    instr_rdata;
    logic          branch;
    logic          branch_taken;
    logic          jmp_ctrl;
    logic [PW-1:0] jump_target;
    logic          done_ctrl;
    logic [PW-1:0] pc;
    logic [8:0]    instruction;
    logic          instr_valid;
    logic          done;
    logic [CW-1:0] cycle_count;

    logic [8:0] rom [256];
    assign instr_rdata = rom[pc];

    fetch_unit #(
        .PC_WIDTH  (PW),
        .CNT_WIDTH (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .instr_rdata  (instr_rdata),
        .branch       (branch),
        .branch_taken (branch_taken),
        .jmp_ctrl     (jmp_ctrl),
        .jump_target  (jump_target),
        .done_ctrl    (done_ctrl),
        .pc           (pc),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .done         (done),
        .cycle_count  (cycle_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [PW-1:0] pc;
        logic          valid;
        logic          done;
        logic [CW-1:0] cnt;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: 0 = not started, 1 = executing, 2 = halted.
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    // One clock of stimulus; the model advances and the expectation is queued.
    task automatic drive(input logic st, input logic [PW-1:0] sa, input logic br,
                         input logic tk, input logic jp, input logic [PW-1:0] jt,
                         input logic dn, input string tag);
        logic [4:0] o;
        int         off;
        exp_t       e;
        @(negedge clock);
        start        = st;
        start_addr   = sa;
        branch       = br;
        branch_taken = tk;
        jmp_ctrl     = jp;
        jump_target  = jt;
        done_ctrl    = dn;
        if (m_mode == 1) begin
            o   = rom[m_pc][4:0];
            off = o[4] ? int'(o) - 32 : int'(o);
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (dn)            m_mode = 2;
            else if (jp)       m_pc = int'(jt);
            else if (br && tk) m_pc = ((m_pc + off) % 256 + 256) % 256;
            else               m_pc = (m_pc + 1) % 256;
        end else if (st) begin
            m_mode = 1;
            m_pc   = int'(sa);
            m_cnt  = 0;
        end
        e.pc    = 8'(m_pc);
        e.valid = (m_mode == 1);
        e.done  = (m_mode == 2);
        e.cnt   = CW'(m_cnt);
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle_cycle(input string tag);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, tag);
    endtask

    // Wait until just after the edge that applies the last driven cycle.
    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Monitor: compares every queued expectation just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk({e.tag, ".pc"},          32'(pc),          32'(e.pc));
                chk({e.tag, ".instr_valid"}, 32'(instr_valid), 32'(e.valid));
                chk({e.tag, ".done"},        32'(done),        32'(e.done));
                chk({e.tag, ".cycle_count"}, 32'(cycle_count), 32'(e.cnt));
                chk({e.tag, ".instruction"}, 32'(instruction), 32'(rom[e.pc]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] halt_instr;
        halt_instr   = {spec_op, 2'b00, hlt_op};
        for (int i = 0; i < 256; i++) rom[i] = 9'h000;
        reset        = 1'b1;
        start        = 1'b0;
        start_addr   = '0;
        branch       = 1'b0;
        branch_taken = 1'b0;
        jmp_ctrl     = 1'b0;
        jump_target  = '0;
        done_ctrl    = 1'b0;

        // Reset values.
        #3;
        chk("rst.pc",          32'(pc),          32'h0);
        chk("rst.instr_valid", 32'(instr_valid), 32'h0);
        chk("rst.done",        32'(done),        32'h0);
        chk("rst.cycle_count", 32'(cycle_count), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        idle_cycle("idle");

        // Sequential run: three adds then halt at 0x13; the bench acts as the decoder.
        rom[8'h10] = 9'b0000_01_001;
        rom[8'h11] = 9'b0000_10_010;
        rom[8'h12] = 9'b0000_11_011;
        rom[8'h13] = halt_instr;
        drive(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "seq.start");
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, is_halt(rom[8'(m_pc)]), "seq.run");
        end
        settle();
        chk("seq.done", 32'(done), 32'h1);
        chk("seq.pc",   32'(pc),   32'h13);
        chk("seq.cnt",  32'(cycle_count), 32'h4);
        // Control inputs are ignored while halted.
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, "halted.ignore");
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, "halted.ignore");

        // Branches at 0x20 with offset -4.
        rom[8'h20] = 9'b0000_1_11100;
        drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "br.start");
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, "br.taken");
        settle();
        chk("br.taken_pc", 32'(pc), 32'h1C);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, "br.jmp_back");
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, "br.not_taken");
        settle();
        chk("br.not_taken_pc", 32'(pc), 32'h21);

        // Wrap-around in both arithmetic paths.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, "wrap.jmp_ff");
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "wrap.fall");
        settle();
        chk("wrap.fall_pc", 32'(pc), 32'h00);
        rom[8'hF5] = 9'b0000_0_01111;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hF5, 1'b0, "wrap.jmp_f5");
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, "wrap.branch");
        settle();
        chk("wrap.branch_pc", 32'(pc), 32'h04);

        // Priority: jump, then jump together with halt.
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h40, 1'b0, "prio.jmp");
        settle();
        chk("prio.jmp_pc", 32'(pc), 32'h40);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99, 1'b1, "prio.jmp_halt");
        settle();
        chk("prio.halt_done", 32'(done), 32'h1);
        chk("prio.halt_pc",   32'(pc),   32'h40);

        // Restart from halt, start during run ignored, then restart at 0x05.
        drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "rs.restart");
        drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "rs.start_in_run");
        settle();
        chk("rs.ignored_pc", 32'(pc), 32'h31);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "rs.halt");
        drive(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "rs.start05");
        settle();
        chk("rs.pc05",  32'(pc),          32'h05);
        chk("rs.cnt0",  32'(cycle_count), 32'h0);
        chk("rs.done0", 32'(done),        32'h0);

        // Asynchronous reset mid-run at 0x33.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, "ar.jmp33");
        settle();
        chk("ar.pc33", 32'(pc), 32'h33);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("ar.pc_async",    32'(pc),          32'h0);
        chk("ar.valid_async", 32'(instr_valid), 32'h0);
        @(negedge clock);
        reset  = 1'b0;
        m_mode = 0;
        m_pc   = 0;
        m_cnt  = 0;
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, "ar.idle");
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "ar.idle");

        // Counter saturation.
        drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, "sat.start");
        for (int i = 0; i < CNT_MAX + 8; i++) idle_cycle("sat.run");
        settle();
        chk("sat.cnt", 32'(cycle_count), 32'(CNT_MAX));

        // Randomized traffic against the model.
        for (int i = 0; i < 256; i++) rom[i] = 9'($urandom);
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(7) == 0), 8'($urandom), ($urandom_range(2) == 0),
                  1'($urandom), ($urandom_range(9) == 0), 8'($urandom),
                  ($urandom_range(19) == 0), "rand");
        end

        settle();
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
